// File: rtl/i2c_fifo_pkg.sv
// Shared constants and types for the APB <-> I2C data FIFOs (TX and RX instances).
package i2c_fifo_pkg;

    localparam int DEF_DWIDTH = 32;
    localparam int DEF_DEPTH  = 16;

    localparam int TX_DEPTH   = 16;
    localparam int RX_DEPTH   = 16;

    typedef logic [DEF_DWIDTH-1:0] data_t;

endpackage

// File: rtl/i2c_fifo_mem.sv
// FIFO storage: register array, one synchronous write port, one asynchronous read port, no reset.
module i2c_fifo_mem #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 16,
    parameter int AWIDTH = $clog2(DEPTH)
) (
    input  logic              PCLK,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge PCLK) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/i2c_data_fifo.sv
// Show-ahead single-clock FIFO with sticky overflow/underflow flags.
// Optional almost-full/almost-empty thresholds enabled by macro I2C_FIFO_THRESHOLD_EN.
module i2c_data_fifo
    import i2c_fifo_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AWIDTH = $clog2(DEPTH)
) (
    input  logic              PCLK,
    input  logic              RESET,
    input  logic              WR_ENA,
    input  logic [DWIDTH-1:0] WDATA,
    input  logic              RD_ENA,
    output logic [DWIDTH-1:0] RDATA,
    output logic              EMPTY,
    output logic              FULL,
    output logic [AWIDTH:0]   COUNT,
`ifdef I2C_FIFO_THRESHOLD_EN
    input  logic [AWIDTH:0]   THRESH,
    output logic              ALMOST_FULL,
    output logic              ALMOST_EMPTY,
`endif
    output logic              OVERFLOW,
    output logic              UNDERFLOW,
    input  logic              CLR_ERR
);

    logic [AWIDTH:0]   wr_ptr, rd_ptr;
    logic              push_acc, pop_acc;
    logic [DWIDTH-1:0] mem_rdata;

    // Wrap bit (MSB) distinguishes full from empty when the indices match.
    assign EMPTY = (wr_ptr == rd_ptr);
    assign FULL  = (wr_ptr[AWIDTH-1:0] == rd_ptr[AWIDTH-1:0]) &&
                   (wr_ptr[AWIDTH] != rd_ptr[AWIDTH]);
    assign COUNT = wr_ptr - rd_ptr;

    // A pop in the same cycle frees the slot, so a push at FULL still lands.
    assign pop_acc  = RD_ENA && !EMPTY;
    assign push_acc = WR_ENA && (!FULL || pop_acc);

    i2c_fifo_mem #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .AWIDTH (AWIDTH)
    ) u_mem (
        .PCLK  (PCLK),
        .we    (push_acc && !RESET),
        .waddr (wr_ptr[AWIDTH-1:0]),
        .wdata (WDATA),
        .raddr (rd_ptr[AWIDTH-1:0]),
        .rdata (mem_rdata)
    );

    assign RDATA = EMPTY ? '0 : mem_rdata;

    always_ff @(posedge PCLK) begin
        if (RESET) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            if (push_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_acc)
                rd_ptr <= rd_ptr + 1'b1;
            // A new error in the same cycle as CLR_ERR keeps the flag set.
            OVERFLOW  <= (WR_ENA && !push_acc) || (OVERFLOW  && !CLR_ERR);
            UNDERFLOW <= (RD_ENA && !pop_acc)  || (UNDERFLOW && !CLR_ERR);
        end
    end

`ifdef I2C_FIFO_THRESHOLD_EN
    logic [AWIDTH+1:0] cnt_x, thr_x, af_lvl;

    assign cnt_x  = {1'b0, COUNT};
    assign thr_x  = {1'b0, THRESH};
    assign af_lvl = (AWIDTH+2)'(DEPTH) - thr_x;

    always_ff @(posedge PCLK) begin
        if (RESET) begin
            ALMOST_FULL  <= 1'b0;
            ALMOST_EMPTY <= 1'b1;
        end else begin
            ALMOST_FULL  <= (cnt_x >= af_lvl);
            ALMOST_EMPTY <= (cnt_x <= thr_x);
        end
    end
`endif

endmodule

// File: tb/tb_i2c_data_fifo.sv
// Self-checking bench for i2c_data_fifo against a queue-based reference model.
module tb_i2c_data_fifo;
    import i2c_fifo_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          PCLK = 1'b0;
    logic          RESET, WR_ENA, RD_ENA, CLR_ERR;
    logic [DW-1:0] WDATA, RDATA;
    logic          EMPTY, FULL, OVERFLOW, UNDERFLOW;
    logic [AW:0]   COUNT;
`ifdef I2C_FIFO_THRESHOLD_EN
    logic [AW:0]   THRESH = 4;
    logic          ALMOST_FULL, ALMOST_EMPTY;
`endif

    int checks = 0;
    int errors = 0;

    data_t m_q[$];
    bit    m_ovf, m_unf;

    always #5 PCLK = ~PCLK;

    i2c_data_fifo #(.DWIDTH(DW), .DEPTH(DEPTH)) dut (
        .PCLK      (PCLK),
        .RESET     (RESET),
        .WR_ENA    (WR_ENA),
        .WDATA     (WDATA),
        .RD_ENA    (RD_ENA),
        .RDATA     (RDATA),
        .EMPTY     (EMPTY),
        .FULL      (FULL),
        .COUNT     (COUNT),
`ifdef I2C_FIFO_THRESHOLD_EN
        .THRESH       (THRESH),
        .ALMOST_FULL  (ALMOST_FULL),
        .ALMOST_EMPTY (ALMOST_EMPTY),
`endif
        .OVERFLOW  (OVERFLOW),
        .UNDERFLOW (UNDERFLOW),
        .CLR_ERR   (CLR_ERR)
    );

    // Reference model: a plain queue with the acceptance rules applied in words.
    task automatic model_upd(input bit wr, input data_t wd, input bit rd, input bit clr, input bit rst);
        bit pop_ok, push_ok;
        if (rst) begin
            m_q.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            pop_ok  = rd && (m_q.size() > 0);
            push_ok = wr && ((m_q.size() < DEPTH) || pop_ok);
            if (pop_ok)  void'(m_q.pop_front());
            if (push_ok) m_q.push_back(wd);
            m_ovf = (wr && !push_ok) || (m_ovf && !clr);
            m_unf = (rd && !pop_ok)  || (m_unf && !clr);
        end
    endtask

    function automatic data_t m_head();
        return (m_q.size() > 0) ? m_q[0] : '0;
    endfunction

    // One clock: drive, take the edge, advance the model, settle 1 time unit past the edge.
    task automatic cyc(input bit wr, input data_t wd, input bit rd, input bit clr, input bit rst);
        WR_ENA = wr; WDATA = wd; RD_ENA = rd; CLR_ERR = clr; RESET = rst;
        @(posedge PCLK);
        model_upd(wr, wd, rd, clr, rst);
        #1;
        WR_ENA = 0; RD_ENA = 0; CLR_ERR = 0; RESET = 0;
    endtask

    task automatic test_reset();
        cyc(0, 0, 0, 0, 1);
        checks++; if (EMPTY !== 1'b1)  begin errors++; $display("FAIL reset_empty got %b exp 1", EMPTY); end
        checks++; if (FULL !== 1'b0)   begin errors++; $display("FAIL reset_full got %b exp 0", FULL); end
        checks++; if (COUNT !== 0)     begin errors++; $display("FAIL reset_count got %0d exp 0", COUNT); end
        checks++; if (RDATA !== 0)     begin errors++; $display("FAIL reset_rdata got %h exp 0", RDATA); end
        checks++; if (OVERFLOW !== 1'b0 || UNDERFLOW !== 1'b0)
            begin errors++; $display("FAIL reset_flags got ovf=%b unf=%b exp 0/0", OVERFLOW, UNDERFLOW); end
        cyc(0, 0, 1, 0, 0);
        checks++; if (UNDERFLOW !== 1'b1) begin errors++; $display("FAIL idle_underflow got %b exp 1", UNDERFLOW); end
        cyc(0, 0, 0, 1, 0);
        checks++; if (UNDERFLOW !== 1'b0) begin errors++; $display("FAIL clr_underflow got %b exp 0", UNDERFLOW); end
    endtask

    task automatic test_push_pop();
        cyc(1, 32'hA5, 0, 0, 0);
        checks++; if (RDATA !== 32'hA5) begin errors++; $display("FAIL push_rdata got %h exp a5", RDATA); end
        checks++; if (COUNT !== 1)      begin errors++; $display("FAIL push_count got %0d exp 1", COUNT); end
        checks++; if (EMPTY !== 1'b0)   begin errors++; $display("FAIL push_empty got %b exp 0", EMPTY); end
        cyc(0, 0, 1, 0, 0);
        checks++; if (EMPTY !== 1'b1 || RDATA !== 0)
            begin errors++; $display("FAIL pop_empty got empty=%b rdata=%h exp 1/0", EMPTY, RDATA); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= DEPTH; i++) cyc(1, data_t'(i), 0, 0, 0);
        checks++; if (FULL !== 1'b1 || COUNT !== DEPTH)
            begin errors++; $display("FAIL fill got full=%b count=%0d exp 1/%0d", FULL, COUNT, DEPTH); end
        cyc(1, 32'hDEAD, 0, 0, 0);
        checks++; if (OVERFLOW !== 1'b1 || COUNT !== DEPTH)
            begin errors++; $display("FAIL overflow got ovf=%b count=%0d exp 1/%0d", OVERFLOW, COUNT, DEPTH); end
        cyc(0, 0, 0, 1, 0);
        checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL clr_overflow got %b exp 0", OVERFLOW); end
        for (int i = 1; i <= DEPTH; i++) begin
            checks++;
            if (RDATA !== data_t'(i)) begin errors++; $display("FAIL drain_%0d got %h exp %h", i, RDATA, i); end
            cyc(0, 0, 1, 0, 0);
        end
        checks++; if (EMPTY !== 1'b1 || RDATA !== 0)
            begin errors++; $display("FAIL drain_end got empty=%b rdata=%h exp 1/0", EMPTY, RDATA); end
    endtask

    task automatic test_simultaneous();
        data_t last;
        for (int i = 1; i <= DEPTH; i++) cyc(1, data_t'(i + 100), 0, 0, 0);
        cyc(1, 32'h77, 1, 0, 0);
        checks++; if (COUNT !== DEPTH || OVERFLOW !== 1'b0 || FULL !== 1'b1)
            begin errors++; $display("FAIL full_pushpop got count=%0d ovf=%b full=%b exp %0d/0/1", COUNT, OVERFLOW, FULL, DEPTH); end
        checks++; if (RDATA !== 32'd102) begin errors++; $display("FAIL full_pushpop_head got %h exp 66", RDATA); end
        last = '0;
        for (int i = 0; i < DEPTH; i++) begin
            last = RDATA;
            cyc(0, 0, 1, 0, 0);
        end
        checks++; if (last !== 32'h77) begin errors++; $display("FAIL full_pushpop_last got %h exp 77", last); end
        cyc(1, 32'h33, 1, 0, 0);
        checks++; if (UNDERFLOW !== 1'b1 || COUNT !== 1 || RDATA !== 32'h33)
            begin errors++; $display("FAIL empty_pushpop got unf=%b count=%0d rdata=%h exp 1/1/33", UNDERFLOW, COUNT, RDATA); end
        cyc(0, 0, 1, 1, 0);
        checks++; if (UNDERFLOW !== 1'b0 || EMPTY !== 1'b1)
            begin errors++; $display("FAIL empty_pushpop_clr got unf=%b empty=%b exp 0/1", UNDERFLOW, EMPTY); end
        // CLR_ERR loses against a same-cycle error
        cyc(0, 0, 1, 1, 0);
        checks++; if (UNDERFLOW !== 1'b1) begin errors++; $display("FAIL clr_vs_err got %b exp 1", UNDERFLOW); end
        cyc(0, 0, 0, 1, 0);
    endtask

    task automatic test_wrap();
        data_t pat = 32'h1000;
        for (int i = 0; i < 40; i++) begin
            bit wr = (i % 2 == 0) || ($urandom_range(0, 3) == 0);
            bit rd = (i % 2 == 1) || ($urandom_range(0, 3) == 0);
            cyc(wr, pat, rd, 0, 0);
            if (wr) pat++;
            checks++;
            if (RDATA !== m_head() || COUNT !== m_q.size() || COUNT > DEPTH)
                begin errors++; $display("FAIL wrap_%0d got rdata=%h count=%0d exp %h/%0d", i, RDATA, COUNT, m_head(), m_q.size()); end
        end
        while (m_q.size() > 0) cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit wr  = ($urandom_range(0, 99) < 55);
            bit rd  = ($urandom_range(0, 99) < 45);
            bit clr = ($urandom_range(0, 99) < 8);
            bit rst = ($urandom_range(0, 99) < 2);
            cyc(wr, data_t'($urandom), rd, clr, rst);
            checks++;
            if (RDATA !== m_head() || COUNT !== m_q.size() || EMPTY !== (m_q.size() == 0) ||
                FULL !== (m_q.size() == DEPTH) || OVERFLOW !== m_ovf || UNDERFLOW !== m_unf)
                begin
                    errors++;
                    $display("FAIL rand_%0d got rd=%h cnt=%0d e=%b f=%b o=%b u=%b exp rd=%h cnt=%0d o=%b u=%b",
                             i, RDATA, COUNT, EMPTY, FULL, OVERFLOW, UNDERFLOW, m_head(), m_q.size(), m_ovf, m_unf);
                end
        end
    endtask

    task automatic test_reset_mid();
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(1, data_t'(32'h500 + i), 0, 0, 0);
        checks++; if (COUNT !== 5) begin errors++; $display("FAIL pre_reset_count got %0d exp 5", COUNT); end
        cyc(1, 32'hBAD, 1, 0, 1);
        checks++; if (COUNT !== 0 || EMPTY !== 1'b1 || RDATA !== 0)
            begin errors++; $display("FAIL mid_reset got count=%0d empty=%b rdata=%h exp 0/1/0", COUNT, EMPTY, RDATA); end
        cyc(1, 32'h99, 0, 0, 0);
        checks++; if (RDATA !== 32'h99 || COUNT !== 1)
            begin errors++; $display("FAIL post_reset_push got rdata=%h count=%0d exp 99/1", RDATA, COUNT); end
    endtask

    initial begin
        RESET = 1; WR_ENA = 0; RD_ENA = 0; CLR_ERR = 0; WDATA = '0;
        test_reset();
        test_push_pop();
        test_fill_overflow();
        test_simultaneous();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_data_fifo.md
# i2c_data_fifo

- Synchronous single-clock FIFO between the APB bridge and the I2C core.
- Used twice in the design:
  - TX instance: the APB bridge pushes writes to address 0; the I2C core pops bytes to send.
  - RX instance: the I2C core pushes received data; the APB bridge pops on reads of address 4.
- Show-ahead (first-word-fall-through) output, so read data is valid in the same APB access cycle that pops it.
- Exports empty/full status for the interrupt lines and sticky overflow/underflow for the slave-error path.

## Interface

Parameters:
- DWIDTH, 32, data word width in bits.
- DEPTH, 16, number of entries; must be a power of two, minimum 2.
- AWIDTH, $clog2(DEPTH), pointer index width (derived; do not override).

Ports:
- PCLK  input  1  single clock; all logic on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- WR_ENA  input  1  push request; one push per cycle high.
- WDATA  input  DWIDTH  data pushed when WR_ENA=1.
- RD_ENA  input  1  pop request; one pop per cycle high.
- RDATA  output  DWIDTH  head-of-queue word; 0 when EMPTY=1.
- EMPTY  output  1  no valid entries.
- FULL  output  1  DEPTH valid entries.
- COUNT  output  AWIDTH+1  number of valid entries, 0..DEPTH.
- OVERFLOW  output  1  sticky; set on a rejected push.
- UNDERFLOW  output  1  sticky; set on a rejected pop.
- CLR_ERR  input  1  clears OVERFLOW and UNDERFLOW.

## Operation

- Storage: DEPTH×DWIDTH register array.
- Pointers: write pointer wr_ptr and read pointer rd_ptr, each AWIDTH+1 bits. The MSB is a wrap bit; index = low AWIDTH bits.
- EMPTY = (wr_ptr == rd_ptr).
- FULL = (index equal AND wrap bits differ).
- COUNT = wr_ptr − rd_ptr, modulo 2^(AWIDTH+1).

Push and pop acceptance:
- Push accepted if WR_ENA and (!FULL or pop accepted this cycle):
  - writes WDATA at wr_ptr index;
  - increments wr_ptr.
- Pop accepted if RD_ENA and !EMPTY:
  - increments rd_ptr.
- Rejected push: memory and pointers unchanged; OVERFLOW ← 1.
- Rejected pop: pointers unchanged; UNDERFLOW ← 1.

Simultaneous events:
- Push + pop when FULL: both accepted; COUNT stays DEPTH; no overflow.
- Push + pop when EMPTY: pop rejected (UNDERFLOW ← 1); push accepted; COUNT becomes 1.
- CLR_ERR concurrent with a new error event: the error wins and the flag stays 1.

Other rules:
- RDATA is combinational from mem[rd_ptr index], gated to 0 when EMPTY.
- Pointers wrap naturally through 2^(AWIDTH+1); no special case at index DEPTH−1 → 0.
- Reset (RESET=1 at a rising edge) overrides every other input, including mid-burst pushes and pops:
  - wr_ptr, rd_ptr, OVERFLOW, UNDERFLOW ← 0;
  - memory contents are not cleared.
- Outputs after reset: EMPTY=1, FULL=0, COUNT=0, RDATA=0, OVERFLOW=0, UNDERFLOW=0.

## Timing

- Write-to-read latency: a word pushed at edge N appears on RDATA and clears EMPTY after edge N (visible in cycle N+1). There is no extra output register.
- Pop: RDATA shows the next word (or 0) in the cycle after the popping edge.
- Status outputs (EMPTY, FULL, COUNT) are derived from registered pointers; glitch-free with respect to inputs.
- OVERFLOW and UNDERFLOW are registered; they assert the cycle after the offending edge.
- Handshake assumption: the APB bridge holds WR_ENA or RD_ENA for exactly one cycle per access (single-cycle PREADY). Every high cycle is a separate request.

## Configuration

- Macro: I2C_FIFO_THRESHOLD_EN.
- When defined:
  - adds input THRESH (AWIDTH+1 bits);
  - adds registered outputs ALMOST_FULL (COUNT ≥ DEPTH − THRESH) and ALMOST_EMPTY (COUNT ≤ THRESH);
  - both outputs update one cycle after COUNT changes;
  - reset values: ALMOST_FULL=0, ALMOST_EMPTY=1.
- When undefined: neither the ports nor the logic exist; the core behaviour is identical.

## Structure

- Package i2c_fifo_pkg holds:
  - default DWIDTH and DEPTH constants;
  - the TX and RX instance depths;
  - a typedef for the DWIDTH-bit data word.
- Sub-module i2c_fifo_mem:
  - register array with one write port and one asynchronous read port;
  - inputs: write enable, write index, write data, read index;
  - no reset.
- Pointers, flags and error logic live in i2c_data_fifo.

## Test plan

- Reset then idle:
  - EMPTY=1, FULL=0, COUNT=0, RDATA=0;
  - RD_ENA pulse → UNDERFLOW=1 the next cycle;
  - CLR_ERR → UNDERFLOW=0.
- Push 0xA5 then pop:
  - the cycle after the push, RDATA=0xA5 and COUNT=1;
  - RD_ENA one cycle → EMPTY=1, RDATA=0.
- Fill and overflow:
  - push 1..16 (DEPTH=16) → FULL=1, COUNT=16;
  - a 17th push (0xDEAD) → OVERFLOW=1, COUNT=16;
  - draining yields 1..16 in order; 0xDEAD is never output.
- Simultaneous push and pop:
  - at FULL with push 0x77 + pop → COUNT stays 16, no OVERFLOW, and 0x77 is read last;
  - at EMPTY with push 0x33 + pop → UNDERFLOW=1, COUNT=1, RDATA=0x33.
- Wrap-around: 40 interleaved push/pop cycles with an incrementing pattern → every word is read back in order and COUNT never exceeds 16.
- Reset mid-operation: with COUNT=5, assert RESET while WR_ENA=1 → next cycle COUNT=0, EMPTY=1, and the pushed word is discarded.
